// File: rtl/seg_pkg.sv
// Shared widths, digit type and the select-to-one-hot helper for the
// 7-segment scan path.
package seg_pkg;
   localparam int BCD_W = 4;
   localparam int SEL_W = 3;

   typedef logic [BCD_W-1:0] bcd_t;

   // One-hot of sel across eight positions; all zeros when sel is not a live digit.
   function automatic logic [7:0] onehot_sel(input logic [SEL_W-1:0] sel, input int n);
      logic [7:0] r;
      r = '0;
      if (int'(sel) < n) r[sel] = 1'b1;
      return r;
   endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side load handshake plus decoder/common drive of the scan controller.
interface seg_scan_ctrl_if
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 8
) ();
   logic                        load;
   logic [BCD_W*NUM_DIGITS-1:0] digits_in;
   logic                        lz_en;
   logic                        pending;
   logic [SEL_W-1:0]            select;
   bcd_t                        cntin;
   logic [NUM_DIGITS-1:0]       digit_en;
   logic                        frame_done;

   modport master (
      output load, digits_in, lz_en,
      input  pending, select, cntin, digit_en, frame_done
   );
   modport slave (
      input  load, digits_in, lz_en,
      output pending, select, cntin, digit_en, frame_done
   );
endinterface

// File: rtl/seg_scan_prescaler.sv
// Slot-length prescaler: counts 0..DIV_MAX, flags the terminal count and
// whether the following cycle falls in the anti-ghost dead window.
module seg_scan_prescaler #(
   parameter int DIV_MAX = 49999,
   parameter int DEAD    = 16
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick,
   output logic in_dead
);
   localparam int CW = $clog2(DIV_MAX + 1);

   logic [CW-1:0] div_cnt;
   logic [CW-1:0] div_nxt;

   always_comb begin
      tick    = (div_cnt == CW'(DIV_MAX));
      div_nxt = tick ? '0 : div_cnt + CW'(1);
      // Looks one cycle ahead so the registered digit enable lines up with div_cnt.
      in_dead = (div_nxt < CW'(DEAD));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div_cnt <= '0;
      else        div_cnt <= div_nxt;
   end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner feeding the shared BCD-to-7-segment decoder,
// with leading-zero blanking, dead time and frame-synchronous updates.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int DIV_MAX    = 49999,
   parameter int DEAD       = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   seg_scan_ctrl_if.slave  bus
);
   localparam int                DW   = BCD_W * NUM_DIGITS;
   localparam logic [SEL_W-1:0]  LAST = SEL_W'(NUM_DIGITS - 1);

   logic                  tick, dead_nxt, wrap, zero_run;
   logic [SEL_W-1:0]      sel_q, sel_nxt;
   logic [DW-1:0]         active_q, active_nxt, shadow_q, shadow_nxt;
   logic                  pending_q, pending_nxt;
   bcd_t                  cntin_q, cntin_nxt;
   logic [NUM_DIGITS-1:0] den_q, den_nxt, supp;
   logic [7:0]            oh;
   logic                  fd_q;

   seg_scan_prescaler #(.DIV_MAX(DIV_MAX), .DEAD(DEAD)) u_pre (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .in_dead (dead_nxt)
   );

   always_comb begin
      wrap    = tick && (sel_q == LAST);
      sel_nxt = sel_q;
      if (tick) sel_nxt = wrap ? '0 : sel_q + SEL_W'(1);

      active_nxt  = active_q;
      shadow_nxt  = shadow_q;
      pending_nxt = pending_q;
      // A load landing on the wrap bypasses the shadow and shows immediately.
      if (wrap) begin
         if (bus.load)       active_nxt = bus.digits_in;
         else if (pending_q) active_nxt = shadow_q;
         pending_nxt = 1'b0;
      end
      if (bus.load) begin
         shadow_nxt = bus.digits_in;
         if (!wrap) pending_nxt = 1'b1;
      end
   end

   // Digit k blanks only when it and every digit above it are zero.
   always_comb begin
      supp     = '0;
      zero_run = bus.lz_en;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run = zero_run && (active_nxt[BCD_W*k +: BCD_W] == '0);
         supp[k]  = zero_run;
      end
   end

   always_comb begin
      cntin_nxt = active_nxt[BCD_W*int'(sel_nxt) +: BCD_W];
      oh        = onehot_sel(sel_nxt, NUM_DIGITS);
      den_nxt   = dead_nxt ? '0 : (oh[NUM_DIGITS-1:0] & ~supp);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q     <= '0;
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         cntin_q   <= '0;
         den_q     <= '0;
         fd_q      <= 1'b0;
      end else begin
         sel_q     <= sel_nxt;
         active_q  <= active_nxt;
         shadow_q  <= shadow_nxt;
         pending_q <= pending_nxt;
         cntin_q   <= cntin_nxt;
         den_q     <= den_nxt;
         fd_q      <= wrap;
      end
   end

   assign bus.select     = sel_q;
   assign bus.cntin      = cntin_q;
   assign bus.digit_en   = den_q;
   assign bus.pending    = pending_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, 10-clock slots, 2-clock dead time.
module tb_seg_scan_ctrl;
   import seg_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

   seg_scan_ctrl #(.NUM_DIGITS(4), .DIV_MAX(9), .DEAD(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycle c is the state seen c negedges after reset release.
   task automatic goto(input int t);
      while (cyc < t) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic pulse_load(input logic [15:0] d);
      bus.digits_in = d;
      bus.load = 1'b1;
      goto(cyc + 1);
      bus.load = 1'b0;
   endtask

   initial begin
      bus.load = 1'b0;
      bus.digits_in = '0;
      bus.lz_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sel", bus.select, 0);
      chk("rst_cntin", bus.cntin, 0);
      chk("rst_den", bus.digit_en, 0);
      chk("rst_pend", bus.pending, 0);
      chk("rst_fd", bus.frame_done, 0);
      rst_n = 1'b1;
      cyc = 0;

      // 1: free-running scan from reset
      for (int c = 0; c <= 40; c++) begin
         goto(c);
         chk($sformatf("scan_sel@%0d", c), bus.select, (c / 10) % 4);
         chk($sformatf("scan_den@%0d", c), bus.digit_en,
             ((c % 10) >= 2) ? (32'd1 << ((c / 10) % 4)) : 32'd0);
         chk($sformatf("scan_fd@%0d", c), bus.frame_done, (c == 40) ? 1 : 0);
         chk($sformatf("scan_cnt@%0d", c), bus.cntin, 0);
      end

      // 2: mid-frame load waits for the wrap
      goto(45);
      pulse_load(16'h1234);
      chk("ld_pend", bus.pending, 1);
      goto(79);
      chk("ld_hold_cnt", bus.cntin, 0);
      chk("ld_hold_pend", bus.pending, 1);
      goto(80);
      chk("ld_wrap_sel", bus.select, 0);
      chk("ld_wrap_cnt", bus.cntin, 4);
      chk("ld_wrap_pend", bus.pending, 0);
      chk("ld_wrap_fd", bus.frame_done, 1);
      chk("ld_wrap_den", bus.digit_en, 0);
      goto(82);  chk("ld_den0", bus.digit_en, 4'b0001);
      goto(90);  chk("ld_cnt1", bus.cntin, 3);
      goto(100); chk("ld_cnt2", bus.cntin, 2);
      goto(110); chk("ld_cnt3", bus.cntin, 1);
      goto(112); chk("ld_den3", bus.digit_en, 4'b1000);

      // 3: leading-zero blanking on and off
      goto(125);
      bus.lz_en = 1'b1;
      pulse_load(16'h0005);
      goto(162); chk("lz_den0", bus.digit_en, 4'b0001); chk("lz_cnt0", bus.cntin, 5);
      goto(172); chk("lz_den1", bus.digit_en, 0);
      goto(182); chk("lz_den2", bus.digit_en, 0);
      goto(192); chk("lz_den3", bus.digit_en, 0);
      goto(195);
      bus.lz_en = 1'b0;
      goto(202); chk("nolz_den0", bus.digit_en, 4'b0001);
      goto(212); chk("nolz_den1", bus.digit_en, 4'b0010);
      goto(222); chk("nolz_den2", bus.digit_en, 4'b0100);
      goto(232); chk("nolz_den3", bus.digit_en, 4'b1000);

      // 4: second load before the wrap replaces the first
      goto(245);
      pulse_load(16'h1111);
      goto(250);
      pulse_load(16'h2222);
      chk("b2b_pend", bus.pending, 1);
      goto(275); chk("b2b_old", bus.cntin, 0);
      goto(280); chk("b2b_c0", bus.cntin, 2); chk("b2b_pend0", bus.pending, 0);
      goto(290); chk("b2b_c1", bus.cntin, 2);
      goto(300); chk("b2b_c2", bus.cntin, 2);
      goto(310); chk("b2b_c3", bus.cntin, 2);

      // 5: load coincident with the wrap goes straight to active
      goto(319);
      chk("law_presel", bus.select, 3);
      pulse_load(16'h9876);
      chk("law_sel", bus.select, 0);
      chk("law_cnt", bus.cntin, 6);
      chk("law_pend", bus.pending, 0);
      chk("law_fd", bus.frame_done, 1);
      goto(330); chk("law_c1", bus.cntin, 7);
      goto(350); chk("law_c3", bus.cntin, 9);

      // 6: asynchronous reset discards pending data
      goto(365);
      pulse_load(16'h4321);
      chk("rp_pend", bus.pending, 1);
      goto(375);
      chk("rp_pre_cnt", bus.cntin, 7);
      chk("rp_pre_den", bus.digit_en, 4'b0010);
      #2 rst_n = 1'b0;
      #1;
      chk("rp_async_sel", bus.select, 0);
      chk("rp_async_cnt", bus.cntin, 0);
      chk("rp_async_den", bus.digit_en, 0);
      chk("rp_async_pend", bus.pending, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      chk("rp_c0_den", bus.digit_en, 0);
      chk("rp_c0_pend", bus.pending, 0);
      goto(2);  chk("rp_c2_den", bus.digit_en, 4'b0001);
      goto(40);
      chk("rp_wrap_fd", bus.frame_done, 1);
      chk("rp_wrap_cnt", bus.cntin, 0);
      chk("rp_wrap_pend", bus.pending, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
